// File: rtl/alt_mult.sv
// alt_mult: 3x3 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier, registered product.
// Build option ALT_MULT_INREG_EN adds an operand register stage (latency 2 vs 1).

module alt_mult_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module alt_mult_fa (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);
    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);
endmodule

module alt_mult (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic [5:0] p,
    output logic       p_valid
);
    logic [2:0] a_op;
    logic [2:0] b_op;
    logic       src_valid;

`ifdef ALT_MULT_INREG_EN
    logic [2:0] a_q;
    logic [2:0] b_q;
    logic       v_q;

    // operand stage: capture A/B and mark that real operands are in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= 3'd0;
            b_q <= 3'd0;
            v_q <= 1'b0;
        end else begin
            a_q <= A;
            b_q <= B;
            v_q <= 1'b1;
        end
    end

    assign a_op      = a_q;
    assign b_op      = b_q;
    assign src_valid = v_q;
`else
    assign a_op      = A;
    assign b_op      = B;
    assign src_valid = 1'b1;
`endif

    // partial products pp[i][j] = a_i & b_j
    logic [2:0] pp0;
    logic [2:0] pp1;
    logic [2:0] pp2;

    assign pp0 = a_op & {3{b_op[0]}};
    assign pp1 = a_op & {3{b_op[1]}};
    assign pp2 = a_op & {3{b_op[2]}};

    logic [5:0] prod;
    logic       c1;
    logic       s2a;
    logic       c2a;
    logic       c2b;
    logic [1:0] c2;
    logic       c3;
    logic       c4;

    // column 0: vertical a0b0
    assign prod[0] = pp0[0];

    // column 1: crosswise a1b0 + a0b1
    alt_mult_ha u_col1 (
        .x (pp0[1]),
        .y (pp1[0]),
        .s (prod[1]),
        .c (c1)
    );

    // column 2: a2b0 + a1b1 + a0b2 + c1, sum up to 4
    alt_mult_fa u_col2a (
        .x (pp0[2]),
        .y (pp1[1]),
        .z (pp2[0]),
        .s (s2a),
        .c (c2a)
    );

    alt_mult_ha u_col2b (
        .x (s2a),
        .y (c1),
        .s (prod[2]),
        .c (c2b)
    );

    // two-bit carry: c2 counts column-3 units (0..2)
    assign c2 = {c2a & c2b, c2a ^ c2b};

    // column 3: a2b1 + a1b2 + c2; c2[1] already weighs as column 4
    alt_mult_fa u_col3 (
        .x (pp1[2]),
        .y (pp2[1]),
        .z (c2[0]),
        .s (prod[3]),
        .c (c3)
    );

    // column 4: a2b2 + carries from column 3 and the high bit of c2
    alt_mult_fa u_col4 (
        .x (pp2[2]),
        .y (c3),
        .z (c2[1]),
        .s (prod[4]),
        .c (c4)
    );

    assign prod[5] = c4;

    // output register: product and validity, reset wins over sampling
    always_ff @(posedge clk) begin
        if (rst) begin
            p       <= 6'd0;
            p_valid <= 1'b0;
        end else begin
            p       <= prod;
            p_valid <= src_valid;
        end
    end

endmodule

// File: tb/tb_alt_mult.sv
// tb_alt_mult: directed self-checking bench for alt_mult.
// Latency follows ALT_MULT_INREG_EN (2 when defined, 1 otherwise).

module tb_alt_mult;

`ifdef ALT_MULT_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] A;
    logic [2:0] B;
    logic [5:0] p;
    logic       p_valid;

    int n_cmp;
    int n_bad;

    alt_mult dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .p       (p),
        .p_valid (p_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // apply one pair and hold it; before LAT edges p keeps prev, then exp
    task automatic run_pair(input logic [2:0] a, input logic [2:0] b,
                            input logic [5:0] exp, input logic [5:0] prev,
                            input string name);
        A = a;
        B = b;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            n_cmp++;
            if (k < LAT) begin
                if (p !== prev) begin
                    n_bad++;
                    $display("FAIL %s early: p=%0d want %0d", name, p, prev);
                end
            end else begin
                if (p !== exp || p_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s: p=%0d v=%b want p=%0d v=1",
                             name, p, p_valid, exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        A   = 3'd7;
        B   = 3'd7;
        tick();
        tick();
        tick();
        n_cmp++;
        if (p !== 6'd0 || p_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: p=%0d v=%b want p=0 v=0", p, p_valid);
        end
    endtask

    task automatic test_zero();
        rst = 1'b0;
        A   = 3'd0;
        B   = 3'd0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            n_cmp++;
            if (p_valid !== (k == LAT) || p !== 6'd0) begin
                n_bad++;
                $display("FAIL zero k=%0d: p=%0d v=%b want p=0 v=%b",
                         k, p, p_valid, k == LAT);
            end
        end
    endtask

    task automatic test_max();
        run_pair(3'b111, 3'b111, 6'b110001, 6'd0, "max");
    endtask

    task automatic test_carry();
        run_pair(3'b101, 3'b011, 6'd15, 6'd49, "carry5x3");
        run_pair(3'b110, 3'b111, 6'd42, 6'd15, "carry6x7");
        run_pair(3'b100, 3'b111, 6'd28, 6'd42, "carry4x7");
        run_pair(3'b011, 3'b011, 6'd9, 6'd28, "carry3x3");
    endtask

    // all 64 pairs back to back; p lags the drive by LAT-1 iterations
    task automatic test_sweep();
        logic [5:0] exp_q[$];
        logic [5:0] want;
        for (int i = 0; i < 64 + LAT - 1; i++) begin
            if (i < 64) begin
                A = 3'(i / 8);
                B = 3'(i % 8);
                exp_q.push_back(6'((i / 8) * (i % 8)));
            end
            tick();
            if (i >= LAT - 1) begin
                want = exp_q.pop_front();
                n_cmp++;
                if (p !== want || p_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sweep i=%0d: p=%0d v=%b want p=%0d v=1",
                             i, p, p_valid, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        A = 3'd7;
        B = 3'd7;
        tick();
        rst = 1'b1;
        A   = 3'd6;
        B   = 3'd5;
        tick();
        n_cmp++;
        if (p !== 6'd0 || p_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst: p=%0d v=%b want p=0 v=0", p, p_valid);
        end
        rst = 1'b0;
        A   = 3'd3;
        B   = 3'd5;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            n_cmp++;
            if (k < LAT) begin
                if (p !== 6'd0 || p_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL midrst stale k=%0d: p=%0d v=%b want p=0 v=0",
                             k, p, p_valid);
                end
            end else begin
                if (p !== 6'd15 || p_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL midrst resume: p=%0d v=%b want p=15 v=1",
                             p, p_valid);
                end
            end
        end
        run_pair(3'b010, 3'b111, 6'd14, 6'd15, "after_rst");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        A     = 3'd0;
        B     = 3'd0;
        test_reset();
        test_zero();
        test_max();
        test_carry();
        test_sweep();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
